// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 deserialiser with a two-flop line synchroniser.
// Frames are loaded at mid stop bit; rda/framing/overrun flags go to the bus interface.
module spart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic       clr_rda,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rda_q, rda_d;
    logic          framing_err_q, framing_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          rxd_s;

    assign rxd_s       = sync_q[1];
    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = framing_err_q;
    assign overrun_err = overrun_err_q;

    // Next-state, counters, shift register and status flags.
    always_comb begin
        sync_d        = {sync_q[0], rxd};
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        framing_err_d = framing_err_q;
        if (clr_rda) begin
            rda_d         = 1'b0;
            overrun_err_d = 1'b0;
        end else begin
            rda_d         = rda_q;
            overrun_err_d = overrun_err_q;
        end
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_d      = S_START;
                        sample_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (sample_cnt_q == MID_START) begin
                        sample_cnt_d = CNT_ZERO;
                        bit_cnt_d    = 4'd0;
                        if (rxd_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (sample_cnt_q == MID_BIT) begin
                        shift_d      = {rxd_s, shift_q[7:1]};
                        bit_cnt_d    = bit_cnt_q + 4'd1;
                        sample_cnt_d = CNT_ZERO;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    // A load in the same cycle as a read leaves the new byte pending.
                    if (sample_cnt_q == MID_BIT) begin
                        rx_data_d     = shift_q;
                        rda_d         = 1'b1;
                        framing_err_d = ~rxd_s;
                        overrun_err_d = rda_q & ~clr_rda;
                        sample_cnt_d  = CNT_ZERO;
                        if (rxd_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_BRK;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                    end
                end
                S_BRK: begin
                    if (rxd_s) begin
                        state_d      = S_IDLE;
                        sample_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = S_BRK;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    sample_cnt_d = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            sample_cnt_q  <= CNT_ZERO;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            sample_cnt_q  <= sample_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: serialises 8N1 frames at 16 ticks/bit, one tick every 4 clk,
// and compares outputs against a frame-level model of the receive status flags.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rxd = 1'b1;
    logic       clr_rda = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun_err;

    int total = 0;
    int bad = 0;

    logic [7:0] m_data;
    logic       m_rda, m_fe, m_ov;

    spart_rx #(.OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rxd(rxd), .clr_rda(clr_rda),
        .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clk
    initial begin
        forever begin
            @(negedge clk) enable = 1'b1;
            @(negedge clk) enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    end

    task automatic model_load(input logic [7:0] b, input logic stop, input logic clr_same);
        m_ov   = m_rda && !clr_same;
        m_rda  = 1'b1;
        m_data = b;
        m_fe   = !stop;
    endtask

    task automatic model_clr();
        m_rda = 1'b0;
        m_ov  = 1'b0;
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(posedge clk);
        while (enable !== 1'b1 && n < 8) begin
            @(posedge clk);
            n++;
        end
        if (enable !== 1'b1) begin
            total++; bad++;
            $display("FAIL tick_timeout: enable=%b want 1 within 8 clk", enable);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_rda = 1'b1;
        @(negedge clk) clr_rda = 1'b0;
    endtask

    // Drives one frame; tick index 0 is the first tick that sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic chk,
                              input logic clr_at_load, input int abort_t);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        wait_tick();
        @(negedge clk) rxd = fr[0];
        for (int t = 0; t < 160; t++) begin
            if (clr_at_load && t == 152) begin
                repeat (3) @(posedge clk);
                @(negedge clk) clr_rda = 1'b1;
                @(posedge clk);
            end else begin
                wait_tick();
            end
            #1;
            if (chk && t == 151) begin
                total++;
                if (rda !== 1'b0) begin
                    bad++; $display("FAIL rda_early: rda=%b at tick 151 want 0", rda);
                end
            end
            if (chk && t == 152) begin
                total++;
                if (rda !== 1'b1) begin
                    bad++; $display("FAIL rda_timing: rda=%b after tick 152 want 1", rda);
                end
            end
            if (t == abort_t) begin
                @(negedge clk);
                rst = 1'b1;
                rxd = 1'b1;
                @(negedge clk);
                total++;
                if ({rx_data, rda, framing_err, overrun_err} !== 11'h000) begin
                    bad++;
                    $display("FAIL reset_mid: data=%h rda=%b fe=%b ov=%b want all 0",
                             rx_data, rda, framing_err, overrun_err);
                end
                rst = 1'b0;
                return;
            end
            if (clr_rda) begin
                @(negedge clk) clr_rda = 1'b0;
            end
            if ((t + 1) % 16 == 0 && t < 159) begin
                @(negedge clk) rxd = fr[(t + 1) / 16];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; clr_rda = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL reset: data=%h rda=%b fe=%b ov=%b want all 0",
                     rx_data, rda, framing_err, overrun_err);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL reset_idle: data=%h rda=%b fe=%b ov=%b want all 0",
                     rx_data, rda, framing_err, overrun_err);
        end
    endtask

    task automatic test_nominal();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
        model_load(8'hA5, 1'b1, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL nominal: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_glitch();
        pulse_clr(); model_clr();
        wait_tick();
        @(negedge clk) rxd = 1'b0;
        repeat (3) wait_tick();
        @(negedge clk) rxd = 1'b1;
        repeat (24) wait_tick();
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL glitch: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h3C, 1'b1, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL after_glitch: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_break();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, -1);
        model_load(8'h0F, 1'b0, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL framing: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
        pulse_clr(); model_clr();
        repeat (640) wait_tick();
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL break_hold: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
        @(negedge clk) rxd = 1'b1;
        repeat (16) wait_tick();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h5A, 1'b1, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL after_break: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_overrun();
        pulse_clr(); model_clr();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h22, 1'b1, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL overrun: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
        pulse_clr(); model_clr();
        total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL overrun_clr: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_simul_read();
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1, -1);
        model_load(8'h44, 1'b1, 1'b1);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL simul_read: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_reset_mid();
        pulse_clr(); model_clr();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 85);
        model_reset();
        repeat (200) wait_tick();
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL aborted_frame: data=%h rda=%b fe=%b ov=%b want all 0",
                     rx_data, rda, framing_err, overrun_err);
        end
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
        model_load(8'h81, 1'b1, 1'b0);
        #1; total++;
        if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
            bad++;
            $display("FAIL after_reset: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                     rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        for (int i = 0; i < 10; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr(); model_clr();
            end
            send_frame(b, stop, 1'b0, 1'b0, -1);
            model_load(b, stop, 1'b0);
            #1; total++;
            if ({rx_data, rda, framing_err, overrun_err} !== {m_data, m_rda, m_fe, m_ov}) begin
                bad++;
                $display("FAIL random[%0d]: data=%h rda=%b fe=%b ov=%b want data=%h rda=%b fe=%b ov=%b",
                         i, rx_data, rda, framing_err, overrun_err, m_data, m_rda, m_fe, m_ov);
            end
            if (!stop) begin
                @(negedge clk) rxd = 1'b1;
                repeat (16) wait_tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_break();
        test_overrun();
        test_simul_read();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
Serial receive half of the SPART. It consumes the one-cycle oversample tick (`enable`) from the divisor-driven baud tick generator and deserialises an asynchronous 8N1 line, LSB first. It presents the received byte and status flags to the SPART bus interface. The bus interface clears the data-available flag when the processor reads the receive buffer.

Parameters:
OVERSAMPLE, 16, enable ticks per bit period; must be an even power of two, 4 or greater; sample counter width is log2(OVERSAMPLE).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  oversample tick from the baud tick generator; one clk wide; OVERSAMPLE ticks per bit
rxd  input  1  serial line; idle high; asynchronous to clk
clr_rda  input  1  one-cycle pulse: processor read of the receive buffer
rx_data  output  8  last received byte
rda  output  1  receive data available
framing_err  output  1  last frame's stop bit sampled low
overrun_err  output  1  a frame completed while rda was still set

Behaviour:
- Reset values: one clock; reset is synchronous and active-high.
  - state=IDLE; sample_cnt=0; bit_cnt=0; shift=0.
  - rx_data=0x00; rda=0; framing_err=0; overrun_err=0.
  - Both synchroniser flops reset to 1.
- Synchroniser:
  - rxd passes through 2 flops to give rxd_s.
  - All line decisions use rxd_s only, so there is 2 clk of input latency.
- Tick gating:
  - sample_cnt, bit_cnt, shift and state advance only on cycles with enable=1.
  - If enable stays 0, everything holds.
- States:
  - IDLE: on a tick with rxd_s=0, go to START with sample_cnt=0.
  - START: sample_cnt increments each tick.
    - At the tick where sample_cnt==OVERSAMPLE/2-1 (mid start bit): if rxd_s=1, treat it as a glitch and return to IDLE with no output change.
    - Otherwise go to DATA with sample_cnt=0 and bit_cnt=0.
  - DATA: sample_cnt increments each tick.
    - At sample_cnt==OVERSAMPLE-1 (mid bit): shift = {rxd_s, shift[7:1]}; bit_cnt increments; sample_cnt=0.
    - After the sample that makes bit_cnt reach 8, go to STOP.
  - STOP: at sample_cnt==OVERSAMPLE-1 (mid stop bit), do a frame load:
    - rx_data<=shift (loaded even on a framing error).
    - rda<=1.
    - framing_err<=~rxd_s.
    - overrun_err<=1 if rda==1 and clr_rda==0 in that cycle, else 0.
    - Next state is IDLE if rxd_s=1, else BREAK.
  - BREAK: wait for a tick with rxd_s=1, then go to IDLE. A line held low never produces a second frame.
- Status flags:
  - Frame load happens at the mid stop bit, so the receiver can detect a following start bit with half a bit of margin.
  - rda, framing_err and overrun_err update in the clk after the qualifying tick, i.e. registered.
  - clr_rda clears rda and overrun_err on the next edge.
  - framing_err holds until the next frame load.
  - If clr_rda and a frame load occur in the same cycle, the load wins: rda=1 and overrun_err=0.
  - clr_rda while rda=0 has no effect.
- Frame timing: from the first tick with rxd_s=0, a frame completes after OVERSAMPLE/2 + 9*OVERSAMPLE ticks, which is 152 ticks at 16.
- Reset mid-frame aborts the frame. No rda is raised and all registers take their reset values.
- Counters never wrap. sample_cnt is zeroed on every state transition and at each bit sample.

Test Plan:
1. Nominal byte (OVERSAMPLE=16, enable every 4 clk, 64 clk/bit): send 0xA5 with stop=1.
   -> rx_data=0xA5, rda=1, framing_err=0, overrun_err=0.
   -> rda rises 1 clk after tick 152, counted from the first low tick.
2. Glitch rejection: hold rxd low for 3 ticks, then high.
   -> returns to IDLE; rda stays 0; rx_data unchanged.
   -> then send 0x3C: rx_data=0x3C, rda=1.
3. Framing error and break: send 0x0F with stop=0, then hold rxd low for 40 bit times.
   -> rx_data=0x0F, rda=1, framing_err=1; no further frame loads.
   -> release rxd high, then send 0x5A: rx_data=0x5A, framing_err=0.
4. Overrun: send 0x11 then 0x22 back-to-back with no clr_rda.
   -> rx_data=0x22, rda=1, overrun_err=1.
   -> pulse clr_rda: rda=0 and overrun_err=0 on the next edge; framing_err unchanged.
5. Simultaneous read and load: with rda=1 holding 0x33, align the clr_rda pulse with the stop-sample tick of 0x44.
   -> rx_data=0x44, rda=1, overrun_err=0.
6. Reset mid-frame: assert rst for 1 clk during DATA bit 4 of 0x81.
   -> all outputs are 0 the clk after rst; rda never rises for the aborted frame.
   -> then send 0x81: rx_data=0x81.
